// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, sitting between IF and
// the memory controller's instruction port. Hits answer next cycle; misses fill one word.
module icache #(
  parameter int CACHE_LINES = 128,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  input  logic              fetchEn_i,
  input  logic [ADDR_W-1:0] fetchAddr_i,
  output logic              fetchRdy_o,
  output logic [31:0]       fetchInst_o,
  output logic              memEn_o,
  output logic [ADDR_W-1:0] memAddr_o,
  input  logic              memRdy_i,
  input  logic [31:0]       memData_i
);

  localparam int INDEX_W = $clog2(CACHE_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                 state_reg;
  logic [CACHE_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]       tag_mem  [CACHE_LINES];
  logic [31:0]            data_mem [CACHE_LINES];

  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               fill_we;
  logic               unused_bits;

  assign fetch_idx = fetchAddr_i[INDEX_W+1:2];
  assign fetch_tag = fetchAddr_i[ADDR_W-1:INDEX_W+2];
  // memAddr_o holds the outstanding miss address, so it doubles as the fill address.
  assign fill_idx  = memAddr_o[INDEX_W+1:2];
  assign fill_tag  = memAddr_o[ADDR_W-1:INDEX_W+2];

  assign lookup_hit  = valid_reg[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign fill_we     = !rst && rdy && !clr_i && (state_reg != S_IDLE) && memRdy_i;
  assign unused_bits = ^fetchAddr_i[1:0];

  // Tag and data storage carry no reset; the valid bits alone gate lookups.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= memData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (fill_we) begin
      valid_reg[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      fetchRdy_o  <= 1'b0;
      fetchInst_o <= '0;
      memEn_o     <= 1'b0;
      memAddr_o   <= '0;
    end else if (rdy) begin
      fetchRdy_o <= 1'b0;
      memEn_o    <= 1'b0;
      if (clr_i) begin
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (fetchEn_i) begin
              if (lookup_hit) begin
                fetchRdy_o  <= 1'b1;
                fetchInst_o <= data_mem[fetch_idx];
              end else begin
                memEn_o   <= 1'b1;
                memAddr_o <= {fetchAddr_i[ADDR_W-1:2], 2'b00};
                state_reg <= S_REQ;
              end
            end
          end
          S_REQ, S_WAIT: begin
            // A response arriving while still in REQ completes the miss just like WAIT.
            if (memRdy_i) begin
              fetchRdy_o  <= 1'b1;
              fetchInst_o <= memData_i;
              state_reg   <= S_IDLE;
            end else begin
              state_reg <= S_WAIT;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
